// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Self-synchronising PRBS checker. It fills a history register
//                from the serial stream, locks once the seed is non-zero, and
//                then predicts, counts and flags mismatching bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int Width      = 4,
    parameter int LossThresh = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        resync,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [0:0] c_SEARCH    = 1'b0;
    localparam logic [0:0] c_LOCKED    = 1'b1;
    localparam logic [3:0] c_FILL_LAST = 4'(Width - 1);
    localparam logic [3:0] c_LOSS      = 4'(LossThresh);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [0:0]       r_state;
    logic [Width-1:0] r_sreg;
    logic [3:0]       r_fill;
    logic [3:0]       r_consec;
    logic             r_locked;
    logic             r_err_pulse;
    logic [15:0]      r_err_count;

    logic [0:0]       w_state_nx;
    logic [Width-1:0] w_sreg_nx;
    logic [3:0]       w_fill_nx;
    logic [3:0]       w_consec_nx;
    logic             w_pulse_nx;
    logic [15:0]      w_count_nx;
    logic [Width-1:0] w_shift_in;
    logic [3:0]       w_consec_inc;
    logic             w_fb;
    logic             w_mismatch;

    // Feedback taps of the maximal-length polynomial for each supported length
    generate
        if (Width == 3) begin : g_w3
            assign w_fb = r_sreg[2] ^ r_sreg[0];
        end else if (Width == 4) begin : g_w4
            assign w_fb = r_sreg[3] ^ r_sreg[0];
        end else if (Width == 5) begin : g_w5
            assign w_fb = r_sreg[4] ^ r_sreg[3] ^ r_sreg[2] ^ r_sreg[0];
        end else if (Width == 6) begin : g_w6
            assign w_fb = r_sreg[5] ^ r_sreg[4] ^ r_sreg[2] ^ r_sreg[1];
        end else if (Width == 7) begin : g_w7
            assign w_fb = r_sreg[6] ^ r_sreg[5] ^ r_sreg[3] ^ r_sreg[0];
        end else if (Width == 8) begin : g_w8
            assign w_fb = r_sreg[7] ^ r_sreg[5] ^ r_sreg[2] ^ r_sreg[1];
        end else if (Width == 9) begin : g_w9
            assign w_fb = r_sreg[8] ^ r_sreg[6] ^ r_sreg[5] ^ r_sreg[4]
                        ^ r_sreg[3] ^ r_sreg[2];
        end else begin : g_unsupported
            assign w_fb = 1'b0;
        end
    endgenerate

    assign w_shift_in   = {r_sreg[Width-2:0], in_bit};
    assign w_consec_inc = r_consec + 4'd1;
    assign w_mismatch   = in_bit ^ w_fb;

    always_comb begin
        w_state_nx  = r_state;
        w_sreg_nx   = r_sreg;
        w_fill_nx   = r_fill;
        w_consec_nx = r_consec;
        w_pulse_nx  = 1'b0;
        w_count_nx  = r_err_count;

        if (resync) begin
            w_state_nx  = c_SEARCH;
            w_fill_nx   = 4'd0;
            w_consec_nx = 4'd0;
        end else if (in_valid) begin
            if (r_state == c_SEARCH) begin
                w_sreg_nx = w_shift_in;
                if (r_fill == c_FILL_LAST) begin
                    // An all-zero seed is the LFSR lock-up state: refill instead
                    w_fill_nx = 4'd0;
                    if (|w_shift_in) begin
                        w_state_nx = c_LOCKED;
                    end
                end else begin
                    w_fill_nx = r_fill + 4'd1;
                end
            end else begin
                // Shift the prediction, not the received bit, so errors stay isolated
                w_sreg_nx = {r_sreg[Width-2:0], w_fb};
                if (w_mismatch) begin
                    w_pulse_nx = 1'b1;
                    if (r_err_count != c_CNT_MAX) begin
                        w_count_nx = r_err_count + 16'd1;
                    end
                    if (w_consec_inc == c_LOSS) begin
                        w_state_nx  = c_SEARCH;
                        w_fill_nx   = 4'd0;
                        w_consec_nx = 4'd0;
                    end else begin
                        w_consec_nx = w_consec_inc;
                    end
                end else begin
                    w_consec_nx = 4'd0;
                end
            end
        end

        if (clear) begin
            w_count_nx = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_SEARCH;
            r_sreg      <= '0;
            r_fill      <= 4'd0;
            r_consec    <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_state     <= w_state_nx;
            r_sreg      <= w_sreg_nx;
            r_fill      <= w_fill_nx;
            r_consec    <= w_consec_nx;
            r_locked    <= (w_state_nx == c_LOCKED);
            r_err_pulse <= w_pulse_nx;
            r_err_count <= w_count_nx;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Scoreboard bench for lfsr_checker (Width=4, LossThresh=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        resync   = 1'b0;
    logic        clear    = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model of the checker and the true transmitter state
    logic        m_state;
    logic [3:0]  m_sreg;
    int          m_fill;
    int          m_consec;
    logic [15:0] m_cnt;
    logic [3:0]  gen;

    lfsr_checker #(.Width(4), .LossThresh(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .resync    (resync),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state  = 1'b0;
        m_sreg   = 4'd0;
        m_fill   = 0;
        m_consec = 0;
        m_cnt    = 16'd0;
    endtask

    task automatic next_true(output logic b);
        b   = gen[3] ^ gen[0];
        gen = {gen[2:0], b};
    endtask

    task automatic drive(input logic v, input logic b, input logic rs, input logic cl);
        logic f;
        logic mp;
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        resync   = rs;
        clear    = cl;
        mp = 1'b0;
        if (rs) begin
            m_state  = 1'b0;
            m_fill   = 0;
            m_consec = 0;
        end else if (v) begin
            if (!m_state) begin
                m_sreg = {m_sreg[2:0], b};
                m_fill = m_fill + 1;
                if (m_fill == 4) begin
                    m_fill = 0;
                    if (m_sreg != 4'd0) m_state = 1'b1;
                end
            end else begin
                f      = m_sreg[3] ^ m_sreg[0];
                m_sreg = {m_sreg[2:0], f};
                if (b != f) begin
                    mp = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_consec = m_consec + 1;
                    if (m_consec == 3) begin
                        m_state  = 1'b0;
                        m_fill   = 0;
                        m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (cl) m_cnt = 16'd0;
        e = {m_state, mp, m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resync   = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({locked, err_pulse, err_count} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset: got locked=%b pulse=%b cnt=%0d, want all 0", locked, err_pulse, err_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] seed;
        logic b;
        exp_t e;
        seed = 4'b0001;
        gen  = 4'b0001;
        for (int i = 0; i < 11; i++) begin
            if (i < 4) b = seed[3-i];
            else next_true(b);
            drive(1'b1, b, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL lock[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
        vectors++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL lock_final: got locked=%b cnt=%0d want 1/0", locked, err_count);
        end
    endtask

    task automatic test_idle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i[0], 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL idle[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
    endtask

    task automatic test_single_error();
        logic b;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            next_true(b);
            drive(1'b1, (i == 1) ? ~b : b, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL single_err[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
        vectors++;
        if (locked !== 1'b1 || err_count !== 16'd1) begin
            miscompares++;
            $display("FAIL single_err_final: got locked=%b cnt=%0d want 1/1", locked, err_count);
        end
    endtask

    task automatic test_zero_seed();
        logic [7:0] pat;
        exp_t e;
        pat = 8'b0000_0001;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        vectors++;
        if ({locked, err_pulse, err_count} !== e) begin
            miscompares++;
            $display("FAIL zero_resync: got %b/%b/%0d want %b/%b/%0d", locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[7-i], 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL zero_seed[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
        gen = 4'b0001;
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_seed_lock: got locked=%b want 1", locked);
        end
    endtask

    task automatic test_loss_of_lock();
        logic b;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            next_true(b);
            drive(1'b1, (i < 3) ? ~b : b, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL loss[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
            if (i == 2) begin
                vectors++;
                if (locked !== 1'b0 || err_count !== 16'd4) begin
                    miscompares++;
                    $display("FAIL loss_drop: got locked=%b cnt=%0d want 0/4", locked, err_count);
                end
            end
        end
    endtask

    task automatic test_clear_collision();
        logic b;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            next_true(b);
            drive(1'b1, (i == 1 || i == 3) ? ~b : b, 1'b0, (i == 3));
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL clear_coll[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_coll_final: got pulse=%b cnt=%0d want 1/0", err_pulse, err_count);
        end
    endtask

    task automatic test_resync();
        logic b;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            next_true(b);
            drive(1'b1, (i == 0) ? ~b : b, (i == 0), 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL resync[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        logic b;
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            next_true(b);
            drive(1'b1, i[0] ? b : ~b, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL pre_reset[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({locked, err_pulse, err_count} !== 18'd0) begin
            miscompares++;
            $display("FAIL async_reset: got locked=%b pulse=%b cnt=%0d want all 0", locked, err_pulse, err_count);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_true(b);
            drive(1'b1, b, 1'b0, 1'b0);
            e = sb.pop_front();
            vectors++;
            if ({locked, err_pulse, err_count} !== e) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got %b/%b/%0d want %b/%b/%0d", i, locked, err_pulse, err_count, e.lk, e.ep, e.cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        gen = 4'b0001;
        test_reset();
        test_lock();
        test_idle();
        test_single_error();
        test_zero_seed();
        test_loss_of_lock();
        test_clear_collision();
        test_resync();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
